// File: rtl/alu_cmd_ctrl_if.sv
// Bundles the RX byte stream, the ALU unit bus and the TX byte stream of alu_cmd_ctrl.
// The master modport is the command controller and the slave modport is its environment.
interface alu_cmd_ctrl_if #(
   parameter int unsigned WIDTH = 16
);
   logic [7:0]       rx_data;
   logic             rx_valid;
   logic [3:0]       unit_en;
   logic [1:0]       func;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] result;
   logic             result_flag;
   logic [7:0]       tx_data;
   logic             tx_valid;
   logic             tx_ready;
   logic             busy;
   logic             cmd_err;

   modport master (
      input  rx_data, rx_valid, result, result_flag, tx_ready,
      output unit_en, func, a, b, tx_data, tx_valid, busy, cmd_err
   );

   modport slave (
      output rx_data, rx_valid, result, result_flag, tx_ready,
      input  unit_en, func, a, b, tx_data, tx_valid, busy, cmd_err
   );
endinterface

// File: rtl/alu_cmd_ctrl.sv
// ALU command front-end: builds opcode/A/B frames from RX bytes, fires one unit for a cycle and
// streams result bytes plus a status byte to TX. ALU_CMD_TIMEOUT_EN adds a mid-frame idle timeout.
module alu_cmd_ctrl #(
   parameter int unsigned WIDTH          = 16,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input logic            clk,
   input logic            rst,
   alu_cmd_ctrl_if.master bus_io
);
   localparam int unsigned N    = WIDTH / 8;
   localparam int unsigned CntW = $clog2(N + 1);

   if ((WIDTH % 8) != 0 || WIDTH < 8 || TIMEOUT_CYCLES == 0) begin : g_param_check
      $error("alu_cmd_ctrl: WIDTH must be a multiple of 8 and TIMEOUT_CYCLES nonzero");
   end

   typedef enum logic [2:0] {StIdle, StGetA, StGetB, StExec, StWait, StSend} state_e;

   state_e            state_q;
   logic [1:0]        sel_q;
   logic [1:0]        func_q;
   logic [WIDTH-1:0]  a_q;
   logic [WIDTH-1:0]  b_q;
   logic [3:0]        unit_en_q;
   logic [CntW-1:0]   rx_cnt_q;
   logic [CntW-1:0]   tx_cnt_q;
   // Result bytes LSB first followed by the status byte; tx_data is always the low byte.
   logic [WIDTH+7:0]  sh_q;
   logic              tx_valid_q;
   logic              busy_q;
   logic              cmd_err_q;

`ifdef ALU_CMD_TIMEOUT_EN
   localparam int unsigned IdleW = $clog2(TIMEOUT_CYCLES + 1);
   logic [IdleW-1:0] idle_q;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         sel_q      <= '0;
         func_q     <= '0;
         a_q        <= '0;
         b_q        <= '0;
         unit_en_q  <= '0;
         rx_cnt_q   <= '0;
         tx_cnt_q   <= '0;
         sh_q       <= '0;
         tx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         cmd_err_q  <= 1'b0;
`ifdef ALU_CMD_TIMEOUT_EN
         idle_q     <= '0;
`endif
      end else begin
         cmd_err_q <= 1'b0;
         unit_en_q <= '0;
         unique case (state_q)
            StIdle: begin
               if (bus_io.rx_valid) begin
                  if (bus_io.rx_data[7:4] != 4'h0) begin
                     cmd_err_q <= 1'b1;
                  end else begin
                     sel_q    <= bus_io.rx_data[3:2];
                     func_q   <= bus_io.rx_data[1:0];
                     rx_cnt_q <= '0;
                     busy_q   <= 1'b1;
                     state_q  <= StGetA;
                  end
               end
            end
            StGetA: begin
               if (bus_io.rx_valid) begin
                  a_q[{rx_cnt_q, 3'b000} +: 8] <= bus_io.rx_data;
                  if (rx_cnt_q == CntW'(N - 1)) begin
                     rx_cnt_q <= '0;
                     state_q  <= StGetB;
                  end else begin
                     rx_cnt_q <= rx_cnt_q + 1'b1;
                  end
               end
            end
            StGetB: begin
               if (bus_io.rx_valid) begin
                  b_q[{rx_cnt_q, 3'b000} +: 8] <= bus_io.rx_data;
                  if (rx_cnt_q == CntW'(N - 1)) begin
                     rx_cnt_q  <= '0;
                     unit_en_q <= 4'b0001 << sel_q;
                     state_q   <= StExec;
                  end else begin
                     rx_cnt_q <= rx_cnt_q + 1'b1;
                  end
               end
            end
            StExec: begin
               state_q <= StWait;
            end
            StWait: begin
               sh_q       <= {7'b0, bus_io.result_flag, bus_io.result};
               tx_cnt_q   <= '0;
               tx_valid_q <= 1'b1;
               state_q    <= StSend;
            end
            StSend: begin
               if (bus_io.tx_ready) begin
                  sh_q <= sh_q >> 8;
                  if (tx_cnt_q == CntW'(N)) begin
                     tx_valid_q <= 1'b0;
                     busy_q     <= 1'b0;
                     state_q    <= StIdle;
                  end else begin
                     tx_cnt_q <= tx_cnt_q + 1'b1;
                  end
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
         endcase

`ifdef ALU_CMD_TIMEOUT_EN
         // Later assignments here win over the case above; it never moves state when rx is idle.
         if ((state_q == StGetA || state_q == StGetB) && !bus_io.rx_valid) begin
            if (idle_q == IdleW'(TIMEOUT_CYCLES - 1)) begin
               idle_q    <= '0;
               rx_cnt_q  <= '0;
               cmd_err_q <= 1'b1;
               busy_q    <= 1'b0;
               state_q   <= StIdle;
            end else begin
               idle_q <= idle_q + 1'b1;
            end
         end else begin
            idle_q <= '0;
         end
`endif
      end
   end

   assign bus_io.unit_en  = unit_en_q;
   assign bus_io.func     = func_q;
   assign bus_io.a        = a_q;
   assign bus_io.b        = b_q;
   assign bus_io.tx_data  = sh_q[7:0];
   assign bus_io.tx_valid = tx_valid_q;
   assign bus_io.busy     = busy_q;
   assign bus_io.cmd_err  = cmd_err_q;
endmodule
